// File: rtl/div255_rem.sv
// Serial remainder/checker downstream of the divide-by-255 unit: r = x - 255*q, one byte per cycle.
// Optional saturating error counter enabled by defining DIV255_REM_ERRCNT_EN.
module div255_rem (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] q,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rem,
  output logic        ok,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] xop_q;
  logic [31:0] qop_q;
  logic        c_q;
  logic        b_q;
  logic [23:0] r_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  rem_q;
  logic        ok_q;

  logic [7:0]  xb_s;
  logic [7:0]  qb_s;
  logic [7:0]  pb_s;
  logic [8:0]  t_s;
  logic [8:0]  u_s;
  logic [31:0] r_full_s;
  logic        ok_d;

  // Byte select: x[i] + q[i] + c, then minus the previous quotient byte (q << 8) and borrow.
  always_comb begin
    xb_s = xop_q[7:0];
    qb_s = qop_q[7:0];
    pb_s = 8'h00;
    case (cnt_q)
      2'd0: begin
        xb_s = xop_q[7:0];
        qb_s = qop_q[7:0];
        pb_s = 8'h00;
      end
      2'd1: begin
        xb_s = xop_q[15:8];
        qb_s = qop_q[15:8];
        pb_s = qop_q[7:0];
      end
      2'd2: begin
        xb_s = xop_q[23:16];
        qb_s = qop_q[23:16];
        pb_s = qop_q[15:8];
      end
      2'd3: begin
        xb_s = xop_q[31:24];
        qb_s = qop_q[31:24];
        pb_s = qop_q[23:16];
      end
      default: begin
        xb_s = 8'h00;
        qb_s = 8'h00;
        pb_s = 8'h00;
      end
    endcase
    t_s      = {1'b0, xb_s} + {1'b0, qb_s} + {8'h00, c_q};
    u_s      = {1'b0, t_s[7:0]} - {1'b0, pb_s} - {8'h00, b_q};
    // Top byte is only meaningful on the last RUN cycle, when the verdict is taken.
    r_full_s = {u_s[7:0], r_q};
    ok_d     = (r_full_s[31:8] == 24'h000000) && (r_full_s[7:0] != 8'hFF);
  end

`ifdef DIV255_REM_ERRCNT_EN
  logic [7:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  // Control FSM, byte datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      xop_q   <= 32'h0000_0000;
      qop_q   <= 32'h0000_0000;
      c_q     <= 1'b0;
      b_q     <= 1'b0;
      r_q     <= 24'h000000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= 8'h00;
      ok_q    <= 1'b0;
`ifdef DIV255_REM_ERRCNT_EN
      err_cnt_q <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            xop_q   <= x;
            qop_q   <= q;
            cnt_q   <= 2'd0;
            c_q     <= 1'b0;
            b_q     <= 1'b0;
            r_q     <= 24'h000000;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          case (cnt_q)
            2'd0:    r_q[7:0]   <= u_s[7:0];
            2'd1:    r_q[15:8]  <= u_s[7:0];
            2'd2:    r_q[23:16] <= u_s[7:0];
            default: r_q        <= r_q;
          endcase
          c_q   <= t_s[8];
          b_q   <= u_s[8];
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rem_q   <= r_full_s[7:0];
            ok_q    <= ok_d;
`ifdef DIV255_REM_ERRCNT_EN
            if (!ok_d && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
              err_cnt_q <= err_cnt_q;
            end
`endif
          end else begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign rem  = rem_q;
  assign ok   = ok_q;

endmodule

// File: tb/tb_div255_rem.sv
// Self-checking bench for div255_rem: directed test-plan vectors plus randomized checks
// against an arithmetic model r = x - 255*q (mod 2^32).
module tb_div255_rem;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [31:0] q;
  logic        busy;
  logic        done;
  logic [7:0]  rem;
  logic        ok;
  logic [7:0]  err_cnt;

  int          n_tests;
  int          n_fail;
  int          exp_err;

  div255_rem dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x       (x),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .rem     (rem),
    .ok      (ok),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_r(input logic [31:0] xv, input logic [31:0] qv);
    return xv - (32'd255 * qv);
  endfunction

  function automatic logic ref_ok(input logic [31:0] xv, input logic [31:0] qv);
    logic [31:0] r;
    r = ref_r(xv, qv);
    return (r < 32'd255);
  endfunction

  task automatic note_err(input logic okv);
`ifdef DIV255_REM_ERRCNT_EN
    if (!okv && exp_err < 255) exp_err++;
`else
    exp_err = 0;
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string name, input logic [31:0] xv, input logic [31:0] qv);
    logic [31:0] r;
    logic        eok;
    r   = ref_r(xv, qv);
    eok = ref_ok(xv, qv);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s done: got %b want 1", name, done);
    end
    n_tests++;
    if (rem !== r[7:0] || ok !== eok) begin
      n_fail++; $display("FAIL %s result x=%h q=%h: got rem=%h ok=%b want rem=%h ok=%b",
                         name, xv, qv, rem, ok, r[7:0], eok);
    end
    note_err(eok);
    n_tests++;
    if (err_cnt !== exp_err[7:0]) begin
      n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, exp_err);
    end
  endtask

  // One full operation from an accepted start, checking busy/done each cycle.
  task automatic do_op(input string name, input logic [31:0] xv, input logic [31:0] qv);
    start = 1'b1; x = xv; q = qv;
    tick();
    start = 1'b0; x = $urandom; q = $urandom;
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL %s cycle%0d busy/done: got %b/%b want 1/0", name, k, busy, done);
      end
      tick();
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy after E4: got %b want 0", name, busy);
    end
    check_result(name, xv, qv);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; x = 32'h0; q = 32'h0;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || rem !== 8'h00 || ok !== 1'b0 || err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset: got busy=%b done=%b rem=%h ok=%b err=%h want 0 0 00 0 00",
                         busy, done, rem, ok, err_cnt);
    end
    rst = 1'b0;
    exp_err = 0;
    tick();
  endtask

  task automatic test_directed;
    do_op("plan_1000_3", 32'd1000, 32'd3);
    n_tests++;
    if (rem !== 8'hEB || ok !== 1'b1) begin
      n_fail++; $display("FAIL plan_1000_3 const: got rem=%h ok=%b want eb 1", rem, ok);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse_width: got %b want 0", done);
    end
    do_op("plan_255_1", 32'd255, 32'd1);
    do_op("plan_255_0", 32'd255, 32'd0);
    n_tests++;
    if (rem !== 8'hFF || ok !== 1'b0) begin
      n_fail++; $display("FAIL plan_255_0 const: got rem=%h ok=%b want ff 0", rem, ok);
    end
    do_op("plan_254_0", 32'd254, 32'd0);
    do_op("wrap_ffff", 32'hFFFF_FFFF, 32'h0101_0101);
    do_op("wrap_100_1", 32'd100, 32'd1);
    n_tests++;
    if (rem !== 8'h65 || ok !== 1'b0) begin
      n_fail++; $display("FAIL wrap_100_1 const: got rem=%h ok=%b want 65 0", rem, ok);
    end
  endtask

  task automatic test_random;
    logic [31:0] xv, qv;
    for (int i = 0; i < 24; i++) begin
      xv = $urandom;
      if (i % 4 == 3) qv = $urandom;
      else qv = (xv / 32'd255) + 32'($urandom_range(0, 2)) - 32'd1;
      do_op("random", xv, qv);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_ignore_start;
    start = 1'b1; x = 32'd5000; q = 32'd19;
    tick();
    start = 1'b1; x = 32'd7; q = 32'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_result("ignore_start", 32'd5000, 32'd19);
  endtask

  task automatic test_back_to_back;
    logic [31:0] x1, q1, x2, q2;
    x1 = 32'd70000; q1 = 32'd274;
    x2 = 32'd255;   q2 = 32'd0;
    start = 1'b1; x = x1; q = q1;
    tick();
    x = x2; q = q2;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) begin
        check_result("b2b_first", x1, q1);
      end else if (k == 9) begin
        check_result("b2b_second", x2, q2);
      end else begin
        n_tests++;
        if (done !== 1'b0) begin
          n_fail++; $display("FAIL b2b done cycle%0d: got %b want 0", k, done);
        end
      end
      if (k == 5) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; x = 32'd255; q = 32'd0;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || rem !== 8'h00 || ok !== 1'b0 || err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b done=%b rem=%h ok=%b err=%h want 0 0 00 0 00",
                         busy, done, rem, ok, err_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid idle%0d: got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    do_op("after_reset_510_2", 32'd510, 32'd2);
  endtask

  task automatic test_errcnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 0;
    for (int i = 0; i < 3; i++) do_op("err3", 32'd255, 32'd0);
`ifdef DIV255_REM_ERRCNT_EN
    n_tests++;
    if (err_cnt !== 8'd3) begin
      n_fail++; $display("FAIL err_cnt_3: got %0d want 3", err_cnt);
    end
    for (int i = 0; i < 300; i++) do_op("err300", 32'd100, 32'd1);
    n_tests++;
    if (err_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL err_cnt_sat: got %0d want 255", err_cnt);
    end
`else
    n_tests++;
    if (err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL err_cnt_off: got %0d want 0", err_cnt);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_err = 0;
    rst = 1'b1; start = 1'b0; x = 32'h0; q = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_errcnt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
